// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control sequencer and program store for the 1-bit accumulator CPU.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/ready/op/arg      host command (HALT, STEP, RUN, RUN_N)
//   cmd_err                     one-cycle pulse when a command is dropped
//   bp_en, bp_addr              PC breakpoint
//   ld_valid/ready/addr/data    program load, accepted only while halted
//   cpu_pc, cpu_data            instruction fetch at the CPU program counter
//   cpu_en                      CPU executes one instruction at the next edge
//   state, bp_hit, step_cnt     status: run state, breakpoint stop, retired count
module cpu_run_ctrl #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [CNT_W-1:0]  cmd_arg,
   output logic              cmd_err,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic              ld_data,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic              cpu_data,
   output logic              cpu_en,
   output logic [1:0]        state,
   output logic              bp_hit,
   output logic [CNT_W-1:0]  step_cnt
);
   localparam logic [1:0] S_HALT = 2'd0, S_RUN = 2'd1, S_RUNN = 2'd2, S_STEP = 2'd3;
   localparam logic [1:0] OP_HALT = 2'd0, OP_STEP = 2'd1, OP_RUN = 2'd2, OP_RUN_N = 2'd3;
   logic [2**ADDR_W-1:0] mem;
   logic [1:0]           state_nx;
   logic [CNT_W-1:0]     rem, rem_nx;
   logic                 first, first_nx, bp_hit_nx, err_nx, bp_match;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_HALT;
         rem      <= '0;
         first    <= 1'b0;
         bp_hit   <= 1'b0;
         cmd_err  <= 1'b0;
         step_cnt <= '0;
         mem      <= '0;
      end else begin
         state    <= state_nx;
         rem      <= rem_nx;
         first    <= first_nx;
         bp_hit   <= bp_hit_nx;
         cmd_err  <= err_nx;
         step_cnt <= step_cnt + CNT_W'(cpu_en);
         if (ld_valid && ld_ready) mem[ld_addr] <= ld_data;
      end
   end
   always_comb begin
      state_nx  = state;
      rem_nx    = rem;
      first_nx  = first && !cpu_en;
      bp_hit_nx = bp_hit;
      err_nx    = 1'b0;
      if (state != S_HALT && bp_match) begin
         state_nx  = S_HALT;
         bp_hit_nx = 1'b1;
      end else if (cmd_valid && cmd_op == OP_HALT) begin
         state_nx = S_HALT;
      end else if (cmd_valid && state == S_HALT) begin
         // RUN_N with a zero count is silently ignored
         if (cmd_op != OP_RUN_N || cmd_arg != '0) begin
            state_nx  = cmd_op == OP_STEP ? S_STEP : cmd_op == OP_RUN ? S_RUN : S_RUNN;
            rem_nx    = cmd_op == OP_RUN_N ? cmd_arg : rem;
            first_nx  = 1'b1;
            bp_hit_nx = 1'b0;
         end
      end else begin
         // a dropped command must not stall STEP/RUNN progress
         err_nx = cmd_valid;
         if (state == S_STEP && cpu_en) state_nx = S_HALT;
         if (state == S_RUNN && cpu_en) begin
            rem_nx = rem - CNT_W'(1);
            if (rem == CNT_W'(1)) state_nx = S_HALT;
         end
      end
   end
   // first suppresses the breakpoint so a resume executes the stopped instruction once
   always_comb begin
      bp_match  = bp_en && cpu_pc == bp_addr && !first && state != S_STEP;
      cpu_en    = state != S_HALT && !bp_match;
      ld_ready  = state == S_HALT;
      cmd_ready = 1'b1;
      cpu_data  = mem[cpu_pc];
   end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl with a simple PC model.
module tb_cpu_run_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_err;
   logic [1:0] cmd_op = 2'd0;
   logic [7:0] cmd_arg = 8'd0;
   logic       bp_en = 1'b0;
   logic [3:0] bp_addr = 4'd0;
   logic       ld_valid = 1'b0, ld_ready, ld_data = 1'b0;
   logic [3:0] ld_addr = 4'd0;
   logic [3:0] pc = 4'd0;
   logic       cpu_data, cpu_en, bp_hit;
   logic [1:0] state;
   logic [7:0] step_cnt;
   int checks = 0, failures = 0, en_cnt = 0;
   always #5 clk = ~clk;
   cpu_run_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_arg(cmd_arg), .cmd_err(cmd_err), .bp_en(bp_en), .bp_addr(bp_addr),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .cpu_pc(pc), .cpu_data(cpu_data), .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit),
      .step_cnt(step_cnt)
   );
   // the PC model advances on each retired instruction, sampled mid-cycle
   task automatic tick();
      logic e, r;
      #4;
      e = cpu_en;
      r = rst;
      if (e) en_cnt++;
      @(posedge clk);
      #1;
      if (r) pc = 4'd0;
      else if (e) pc = pc + 4'd1;
   endtask
   task automatic issue(input logic [1:0] op, input logic [7:0] arg);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_arg = arg;
      tick();
      cmd_valid = 1'b0;
   endtask
   task automatic run_to_halt();
      int n = 0;
      while (state !== 2'd0 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (state !== 2'd0) begin failures++; $display("FAIL halt_timeout state=%0d exp=0", state); end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks += 6;
      if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
      if (cpu_en !== 1'b0) begin failures++; $display("FAIL rst_cpu_en got=%0b exp=0", cpu_en); end
      if (step_cnt !== 8'd0) begin failures++; $display("FAIL rst_step_cnt got=%0d exp=0", step_cnt); end
      if (bp_hit !== 1'b0 || cmd_err !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b%0b exp=00", bp_hit, cmd_err); end
      if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_ld_ready got=%0b exp=1", ld_ready); end
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready got=%0b exp=1", cmd_ready); end
   endtask
   task automatic test_load_step();
      logic [3:0] prog = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         ld_addr = 4'(i);
         ld_data = prog[i];
         tick();
      end
      ld_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pc = 4'(i);
         #1;
         checks++;
         if (cpu_data !== prog[i]) begin failures++; $display("FAIL load_read[%0d] got=%0b exp=%0b", i, cpu_data, prog[i]); end
      end
      pc = 4'd0;
      for (int s = 1; s <= 2; s++) begin
         issue(2'd1, 8'd0);
         checks += 4;
         if (state !== 2'd3) begin failures++; $display("FAIL step%0d_state got=%0d exp=3", s, state); end
         if (cpu_en !== 1'b1) begin failures++; $display("FAIL step%0d_en got=%0b exp=1", s, cpu_en); end
         tick();
         if (cpu_en !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL step%0d_done en=%0b state=%0d exp en=0 state=0", s, cpu_en, state); end
         if (pc !== 4'(s)) begin failures++; $display("FAIL step%0d_pc got=%0d exp=%0d", s, pc, s); end
      end
      checks++;
      if (step_cnt !== 8'd2) begin failures++; $display("FAIL step_cnt got=%0d exp=2", step_cnt); end
   endtask
   task automatic test_run_n();
      en_cnt = 0;
      issue(2'd3, 8'd5);
      checks += 6;
      if (state !== 2'd2) begin failures++; $display("FAIL runn_state got=%0d exp=2", state); end
      repeat (4) tick();
      if (state !== 2'd2) begin failures++; $display("FAIL runn_mid got=%0d exp=2", state); end
      tick();
      if (state !== 2'd0 || cpu_en !== 1'b0) begin failures++; $display("FAIL runn_end state=%0d en=%0b exp state=0 en=0", state, cpu_en); end
      repeat (3) tick();
      if (en_cnt !== 5) begin failures++; $display("FAIL runn_count got=%0d exp=5", en_cnt); end
      if (step_cnt !== 8'd7) begin failures++; $display("FAIL runn_step_cnt got=%0d exp=7", step_cnt); end
      if (pc !== 4'd7) begin failures++; $display("FAIL runn_pc got=%0d exp=7", pc); end
      issue(2'd3, 8'd0);
      checks += 2;
      if (state !== 2'd0 || cpu_en !== 1'b0) begin failures++; $display("FAIL runn0 state=%0d en=%0b exp state=0 en=0", state, cpu_en); end
      if (cmd_err !== 1'b0) begin failures++; $display("FAIL runn0_err got=%0b exp=0", cmd_err); end
   endtask
   task automatic test_breakpoint();
      pc = 4'd0;
      bp_en = 1'b1;
      bp_addr = 4'd3;
      en_cnt = 0;
      issue(2'd2, 8'd0);
      run_to_halt();
      checks += 4;
      if (en_cnt !== 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", en_cnt); end
      if (pc !== 4'd3) begin failures++; $display("FAIL bp_pc got=%0d exp=3", pc); end
      if (bp_hit !== 1'b1) begin failures++; $display("FAIL bp_hit got=%0b exp=1", bp_hit); end
      if (step_cnt !== 8'd10) begin failures++; $display("FAIL bp_step_cnt got=%0d exp=10", step_cnt); end
      en_cnt = 0;
      issue(2'd2, 8'd0);
      checks += 2;
      if (bp_hit !== 1'b0) begin failures++; $display("FAIL resume_bp_clear got=%0b exp=0", bp_hit); end
      if (cpu_en !== 1'b1) begin failures++; $display("FAIL resume_en got=%0b exp=1", cpu_en); end
      run_to_halt();
      checks += 4;
      if (en_cnt !== 16) begin failures++; $display("FAIL wrap_count got=%0d exp=16", en_cnt); end
      if (pc !== 4'd3) begin failures++; $display("FAIL wrap_pc got=%0d exp=3", pc); end
      if (bp_hit !== 1'b1) begin failures++; $display("FAIL wrap_bp_hit got=%0b exp=1", bp_hit); end
      if (step_cnt !== 8'd26) begin failures++; $display("FAIL wrap_step_cnt got=%0d exp=26", step_cnt); end
      bp_en = 1'b0;
   endtask
   task automatic test_run_cmds();
      issue(2'd2, 8'd0);
      tick();
      tick();
      ld_valid = 1'b1;
      ld_addr = 4'd1;
      ld_data = 1'b1;
      #1;
      checks += 5;
      if (ld_ready !== 1'b0) begin failures++; $display("FAIL run_ld_ready got=%0b exp=0", ld_ready); end
      issue(2'd1, 8'd0);
      ld_valid = 1'b0;
      if (cmd_err !== 1'b1 || state !== 2'd1) begin failures++; $display("FAIL run_err err=%0b state=%0d exp err=1 state=1", cmd_err, state); end
      tick();
      if (cmd_err !== 1'b0 || state !== 2'd1) begin failures++; $display("FAIL run_err_pulse err=%0b state=%0d exp err=0 state=1", cmd_err, state); end
      en_cnt = 0;
      issue(2'd0, 8'd0);
      if (state !== 2'd0 || cpu_en !== 1'b0) begin failures++; $display("FAIL halt_cmd state=%0d en=%0b exp state=0 en=0", state, cpu_en); end
      tick();
      if (en_cnt !== 1) begin failures++; $display("FAIL halt_retire got=%0d exp=1", en_cnt); end
      checks += 3;
      if (step_cnt !== 8'd31) begin failures++; $display("FAIL halt_step_cnt got=%0d exp=31", step_cnt); end
      if (pc !== 4'd8) begin failures++; $display("FAIL halt_pc got=%0d exp=8", pc); end
      pc = 4'd1;
      #1;
      if (cpu_data !== 1'b0) begin failures++; $display("FAIL run_ld_ignored got=%0b exp=0", cpu_data); end
   endtask
   task automatic test_same_cycle();
      pc = 4'd1;
      ld_valid = 1'b1;
      ld_addr = 4'd1;
      ld_data = 1'b1;
      issue(2'd1, 8'd0);
      ld_valid = 1'b0;
      checks += 3;
      if (cpu_en !== 1'b1) begin failures++; $display("FAIL same_en got=%0b exp=1", cpu_en); end
      if (cpu_data !== 1'b1) begin failures++; $display("FAIL same_data got=%0b exp=1", cpu_data); end
      tick();
      if (pc !== 4'd2 || step_cnt !== 8'd32) begin failures++; $display("FAIL same_after pc=%0d cnt=%0d exp pc=2 cnt=32", pc, step_cnt); end
   endtask
   task automatic test_reset_mid();
      issue(2'd3, 8'd5);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks += 3;
      if (state !== 2'd0 || cpu_en !== 1'b0) begin failures++; $display("FAIL midrst state=%0d en=%0b exp state=0 en=0", state, cpu_en); end
      if (step_cnt !== 8'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", step_cnt); end
      if (bp_hit !== 1'b0) begin failures++; $display("FAIL midrst_bp got=%0b exp=0", bp_hit); end
      for (int i = 0; i < 16; i++) begin
         pc = 4'(i);
         #1;
         checks++;
         if (cpu_data !== 1'b0) begin failures++; $display("FAIL midrst_mem[%0d] got=%0b exp=0", i, cpu_data); end
      end
      checks++;
      tick();
      if (state !== 2'd0) begin failures++; $display("FAIL midrst_stay got=%0d exp=0", state); end
   endtask
   initial begin
      test_reset();
      test_load_step();
      test_run_n();
      test_breakpoint();
      test_run_cmds();
      test_same_cycle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
